// File: rtl/pf_ddr3_iod_eye_trainer.sv
// Eye trainer for one PolarFire DDR3 IOD lane: steps the input delay until the eye monitor is centred.
// Latency: LOAD pulse the cycle after START; each window costs 2 + SETTLE_CYCLES + SAMPLE_CYCLES cycles (+1 on a move).
// Backpressure: none; START is level-sampled only in IDLE/DONE/ERR and ignored while training.
module pf_ddr3_iod_eye_trainer #(
  parameter int LOAD_TAP      = 1,
  parameter int TAP_MAX       = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int LOCK_WINDOWS  = 4,
  parameter int MAX_WINDOWS   = 255
) (
  input  logic       FAB_CLK,
  input  logic       RESET_N,
  input  logic       TRAIN_START,
  output logic       TRAIN_BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_ERR,
  output logic [7:0] TAP_VAL,
  output logic       DELAY_LINE_LOAD_0,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  output logic       EYE_MONITOR_CLEAR_FLAGS_0,
  input  logic       EYE_MONITOR_EARLY_0,
  input  logic       EYE_MONITOR_LATE_0,
  input  logic       DELAY_LINE_OUT_OF_RANGE_0
);

  // One counter serves both the settle and the sample phase, so size it for the longer one.
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int WW      = $clog2(MAX_WINDOWS + 1);
  localparam int LW      = $clog2(LOCK_WINDOWS + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [WW-1:0] WIN_LIMIT   = WW'(MAX_WINDOWS);
  localparam logic [LW-1:0] LOCK_TARGET = LW'(LOCK_WINDOWS);
  localparam logic [7:0]    TAP_LOAD    = 8'(LOAD_TAP);
  localparam logic [7:0]    TAP_TOP     = 8'(TAP_MAX);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DECIDE,
    ST_MOVE,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] phase_cnt;
  logic [WW-1:0] win_cnt;
  logic [LW-1:0] lock_cnt;
  logic          early_acc;
  logic          late_acc;
  logic          oor_acc;

  logic          early_fin;
  logic          late_fin;
  logic [LW-1:0] lock_next;
  logic          clean;
  logic          locking;

  // Accumulator values including the current sample, and the lock decision for DECIDE.
  always_comb begin
    early_fin = early_acc | EYE_MONITOR_EARLY_0;
    late_fin  = late_acc | EYE_MONITOR_LATE_0;
    lock_next = lock_cnt + 1'b1;
    clean     = !early_acc && !late_acc;
    locking   = clean && (lock_next == LOCK_TARGET);
  end

  // Training FSM; every output is a register so pulses are glitch-free toward the IOD.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state                     <= ST_IDLE;
      phase_cnt                 <= '0;
      win_cnt                   <= '0;
      lock_cnt                  <= '0;
      early_acc                 <= 1'b0;
      late_acc                  <= 1'b0;
      oor_acc                   <= 1'b0;
      TRAIN_BUSY                <= 1'b0;
      TRAIN_DONE                <= 1'b0;
      TRAIN_ERR                 <= 1'b0;
      TAP_VAL                   <= TAP_LOAD;
      DELAY_LINE_LOAD_0         <= 1'b0;
      DELAY_LINE_MOVE_0         <= 1'b0;
      DELAY_LINE_DIRECTION_0    <= 1'b1;
      EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
    end else begin
      // Pulses default low so each one lasts exactly the single state cycle that sets it.
      DELAY_LINE_LOAD_0         <= 1'b0;
      DELAY_LINE_MOVE_0         <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (TRAIN_START) begin
            state             <= ST_LOAD;
            DELAY_LINE_LOAD_0 <= 1'b1;
            TRAIN_BUSY        <= 1'b1;
            TRAIN_DONE        <= 1'b0;
            TRAIN_ERR         <= 1'b0;
            win_cnt           <= '0;
            lock_cnt          <= '0;
            TAP_VAL           <= TAP_LOAD;
          end
        end
        ST_LOAD: begin
          state                     <= ST_CLEAR;
          EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b1;
        end
        ST_CLEAR: begin
          early_acc <= 1'b0;
          late_acc  <= 1'b0;
          oor_acc   <= 1'b0;
          phase_cnt <= '0;
          state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (phase_cnt == SETTLE_LAST) begin
            phase_cnt <= '0;
            state     <= ST_SAMPLE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          early_acc <= early_fin;
          late_acc  <= late_fin;
          oor_acc   <= oor_acc | DELAY_LINE_OUT_OF_RANGE_0;
          if (phase_cnt == SAMPLE_LAST) begin
            state <= ST_DECIDE;
            if (win_cnt != WIN_LIMIT) begin
              win_cnt <= win_cnt + 1'b1;
            end
            // Direction is committed as DECIDE begins so it is already stable the cycle before MOVE.
            if (early_fin ^ late_fin) begin
              DELAY_LINE_DIRECTION_0 <= early_fin;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_DECIDE: begin
          if (oor_acc || (win_cnt == WIN_LIMIT && !locking)) begin
            state      <= ST_ERR;
            TRAIN_ERR  <= 1'b1;
            TRAIN_BUSY <= 1'b0;
          end else if (clean) begin
            lock_cnt <= lock_next;
            if (locking) begin
              state      <= ST_DONE;
              TRAIN_DONE <= 1'b1;
              TRAIN_BUSY <= 1'b0;
            end else begin
              state                     <= ST_CLEAR;
              EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b1;
            end
          end else if (early_acc && late_acc) begin
            // Jitter straddles the sample point: restart the lock count but leave the tap alone.
            lock_cnt                  <= '0;
            state                     <= ST_CLEAR;
            EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b1;
          end else begin
            lock_cnt <= '0;
            if ((early_acc && TAP_VAL == TAP_TOP) || (late_acc && TAP_VAL == 8'd0)) begin
              state      <= ST_ERR;
              TRAIN_ERR  <= 1'b1;
              TRAIN_BUSY <= 1'b0;
            end else begin
              state             <= ST_MOVE;
              DELAY_LINE_MOVE_0 <= 1'b1;
            end
          end
        end
        ST_MOVE: begin
          TAP_VAL                   <= DELAY_LINE_DIRECTION_0 ? TAP_VAL + 8'd1 : TAP_VAL - 8'd1;
          state                     <= ST_CLEAR;
          EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          TRAIN_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
